// File: rtl/tri_st_mult_pkg.sv
// tri_st_mult_pkg: shared FSM state and radix-4 Booth select encodings
package tri_st_mult_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    typedef struct packed {
        logic neg;
        logic x;
        logic x2;
    } booth_sel_t;

    // Radix-4 Booth recode of the triplet {b[2k+1], b[2k], b[2k-1]}
    function automatic booth_sel_t booth_recode(input logic [2:0] b);
        return '{neg: b[2] & ~(b[1] & b[0]),
                 x:   b[1] ^ b[0],
                 x2:  (b[2] & ~b[1] & ~b[0]) | (~b[2] & b[1] & b[0])};
    endfunction

endpackage

// File: rtl/tri_st_mult_boothrow_n.sv
// tri_st_mult_boothrow_n: one Booth partial-product row (0, +-A, +-2A) with hot-one for negation
module tri_st_mult_boothrow_n #(
    parameter int W = 34
) (
    input  logic         neg,
    input  logic         x,
    input  logic         x2,
    input  logic [W-1:0] a,
    output logic [W:0]   row,
    output logic         hot_one
);

    logic [W:0] mag;

    // Select magnitude, then ones-complement it; the +1 is carried by hot_one
    always_comb begin
        mag     = x ? {a[W-1], a} : x2 ? {a, 1'b0} : '0;
        row     = neg ? ~mag : mag;
        hot_one = neg;
    end

endmodule

// File: rtl/tri_st_mult_booth_seq.sv
// tri_st_mult_booth_seq: sequential radix-4 Booth multiplier with valid/ready handshake
module tri_st_mult_booth_seq
    import tri_st_mult_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic                 nclk,
    input  logic                 rst_n,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic                 in_sgn,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 flush,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [2*WIDTH-1:0]   out_prod
);

    localparam int W2  = WIDTH + 2;
    localparam int N   = W2 / 2;
    localparam int R   = ROWS_PER_CYCLE;
    localparam int CYC = (N + R - 1) / R;
    localparam int AW  = 2 * W2;
    localparam int CW  = $clog2(CYC + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W2-1:0]   a_x;
    logic [W2:0]     mq;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_nxt;
    booth_sel_t      sel [R];
    logic [W2:0]     row [R];
    logic            hot [R];

    // Multiplier shifts right arithmetically, so rows past the top recode to zero
    for (genvar i = 0; i < R; i++) begin : g_row
        assign sel[i] = booth_recode(mq[2*i+2 -: 3]);
        tri_st_mult_boothrow_n #(.W(W2)) u_row (
            .neg     (sel[i].neg),
            .x       (sel[i].x),
            .x2      (sel[i].x2),
            .a       (a_x),
            .row     (row[i]),
            .hot_one (hot[i])
        );
    end

    // Add this cycle's rows, each weighted by 4^k where k is its absolute row index
    always_comb begin
        acc_nxt = acc;
        for (int r = 0; r < R; r++)
            acc_nxt = acc_nxt + (({{(AW-W2-1){row[r][W2]}}, row[r]} + AW'(hot[r]))
                                 << (2 * ((CYC - int'(cnt)) * R + r)));
    end

    // FSM, operand latch, row counter and accumulator
    always_ff @(posedge nclk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_x   <= '0;
            mq    <= '0;
            acc   <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (in_val) begin
                    state <= ST_BUSY;
                    a_x   <= {{2{in_sgn & in_a[WIDTH-1]}}, in_a};
                    mq    <= {{2{in_sgn & in_b[WIDTH-1]}}, in_b, 1'b0};
                    acc   <= '0;
                    cnt   <= CW'(CYC);
                end
                ST_BUSY: if (cnt == '0) begin
                    state <= ST_DONE;
                end else begin
                    acc <= acc_nxt;
                    mq  <= $signed(mq) >>> (2 * R);
                    cnt <= cnt - 1'b1;
                end
                ST_DONE: if (out_rdy) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state register; product gated by out_val
    always_comb begin
        in_rdy   = state == ST_IDLE;
        out_val  = state == ST_DONE;
        out_prod = out_val ? acc[2*WIDTH-1:0] : '0;
    end

endmodule

// File: doc/tri_st_mult_booth_seq.md
TRI_ST_MULT_BOOTH_SEQ -- requirements
Module: tri_st_mult_booth_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; even, 8..64.
REQ-002 SHALL have parameter ROWS_PER_CYCLE, default 1, number of radix-4 Booth rows accumulated per cycle; 1 or 2.
REQ-003 SHALL have port nclk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port in_val, input, 1, the operand set is valid.
REQ-006 SHALL have port in_rdy, output, 1, the block accepts operands.
REQ-007 SHALL have port in_sgn, input, 1, 1 = signed multiply, 0 = unsigned.
REQ-008 SHALL have ports in_a and in_b, input, WIDTH each: multiplicand and multiplier.
REQ-009 SHALL have port flush, input, 1, abandons any operation in flight.
REQ-010 SHALL have port out_val, output, 1, the result is valid.
REQ-011 SHALL have port out_rdy, input, 1, the consumer accepts the result.
REQ-012 SHALL have port out_prod, output, 2*WIDTH, the product.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 SHALL drive in_rdy=1 only in IDLE; an operation is accepted when in_val&in_rdy, and the FSM then goes IDLE->BUSY.
REQ-015 SHALL latch in_a, in_b and in_sgn on accept; later input changes SHALL have no effect.
REQ-016 SHALL extend both operands to WIDTH+2 bits internally: sign-extended when in_sgn=1, zero-extended when in_sgn=0.
REQ-017 SHALL recode the multiplier radix-4 into N=(WIDTH+2)/2 rows; each row selects 0, +-A or +-2A, and negation is ones-complement plus a hot-one at the row LSB.
REQ-018 SHALL accumulate ROWS_PER_CYCLE rows per BUSY cycle into an accumulator of at least 2*WIDTH+4 bits, scanning rows from the LSB group upward, with row k weighted by 4^k.
REQ-019 SHALL hold a row counter that counts down from ceil(N/ROWS_PER_CYCLE); BUSY->DONE when it reaches 0.
REQ-020 Latency, accept to out_val: ceil(N/ROWS_PER_CYCLE)+1 cycles (18 for the defaults).
REQ-021 SHALL assert out_val only in DONE, with out_prod = the low 2*WIDTH bits of the exact product, held stable until out_val&out_rdy.
REQ-022 SHALL return DONE->IDLE on out_val&out_rdy; in_rdy SHALL rise in the following cycle, so there is no same-cycle re-accept.
REQ-023 SHALL have flush=1 force IDLE on the next edge from any state, drop the operation and never assert out_val for it; a flush in the same cycle as an accept cancels that accept.
REQ-024 With out_rdy=0, the block SHALL stay in DONE indefinitely, with no overwrite.
REQ-025 SHALL drive out_prod=0 whenever out_val=0.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, set the FSM to IDLE and clear the accumulator, the row counter and the latched operands; in_rdy is therefore 1 in the cycle after release.
REQ-027 SHALL treat reset mid-BUSY or mid-DONE as a flush: no out_val for the lost operation.
REQ-028 Reset values: in_rdy=1, out_val=0, out_prod=0.

Structure
REQ-029 SHALL define the FSM state encoding and the Booth select encoding (neg, x, x2) as typedefs/constants in the shared tri_st_mult_pkg package.
REQ-030 SHALL instantiate ROWS_PER_CYCLE copies of one sub-module, tri_st_mult_boothrow_n (parametrised WIDTH+2 Booth row: inputs neg/x/x2 and the multiplicand; outputs the row and the hot_one).
REQ-031 The top level SHALL contain only the FSM, the counter, the recoder, the accumulator and the handshake logic; the multiply itself is a single shift-add loop with no tree.

Verification
REQ-032 Unsigned 3*5, WIDTH=32, out_rdy=1: out_prod=0x000000000000000F, with out_val exactly 18 cycles after accept.
REQ-033 Unsigned 0xFFFFFFFF*0xFFFFFFFF, then signed: 0xFFFFFFFE00000001 for unsigned and 0x0000000000000001 for signed (-1*-1).
REQ-034 Signed 0x80000000*0x80000000: 0x4000000000000000; signed 0x80000000*1: 0xFFFFFFFF80000000.
REQ-035 out_rdy=0 for 10 cycles after out_val: out_prod is stable, in_rdy=0, and a single transfer occurs when out_rdy rises.
REQ-036 flush at cycle 5 of BUSY, then a new op 7*9: no result for the first op; the second yields 63 after full latency.
REQ-037 rst_n=0 mid-BUSY for 1 cycle: the cycle after release has in_rdy=1, out_val=0 and no stale result; repeat REQ-032 to REQ-034 with ROWS_PER_CYCLE=2 (latency 10) and WIDTH=8.
